scaler_prescaler: RTL and testbench

- Upstream feeder of the scaler ripple chain. Divides SIM_CLK down to the first scaler phase, FS01/FS01_, which clocks the FS02..FS05 stage block.
- Emits one-cycle F01A/F01B strobes on FS01 rise/fall for timing consumers.
- Start/stop sequencing guarantees FS01 never produces a runt pulse.
- Optionally watches FS02 coming back from the downstream stage and flags a scaler failure.

---
 rtl/scaler_pkg.sv | 17 +
 rtl/scaler_alarm_mon.sv | 60 ++++++
 rtl/scaler_prescaler.sv | 127 ++++++++++++
 tb/tb_scaler_prescaler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared types and constants for the scaler prescaler and its alarm monitor.
package scaler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned SCALER_DIV_HALF_DEF    = 20;
  localparam int unsigned SCALER_ALARM_LIMIT_DEF = 4;

  // Bits needed to hold 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scaler_alarm_mon.sv
// Scaler failure monitor: flags SCAFAL when FS02 stops following FS01.
// Instantiated by scaler_prescaler only when SCALER_ALARM_EN is defined.
module scaler_alarm_mon
  import scaler_pkg::*;
#(
  parameter int unsigned ALARM_LIMIT = SCALER_ALARM_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fs02,
  input  logic f01a,
  input  logic running,
  input  logic run_entry,
  output logic scafal
);

  localparam int unsigned EW = $clog2(ALARM_LIMIT + 1);
  localparam logic [EW-1:0] LIM = EW'(ALARM_LIMIT);

  logic          sync1_q, sync2_q, prev_q;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic          scafal_q, scafal_d;
  logic          fs02_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      edge_cnt_q <= '0;
      scafal_q   <= 1'b0;
    end else begin
      sync1_q    <= fs02;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      edge_cnt_q <= edge_cnt_d;
      scafal_q   <= scafal_d;
    end
  end

  // Any FS02 activity proves the downstream stage is alive; a clear beats a count.
  always_comb begin
    fs02_chg   = sync2_q ^ prev_q;
    edge_cnt_d = edge_cnt_q;
    scafal_d   = scafal_q;
    if (run_entry || fs02_chg) begin
      edge_cnt_d = '0;
    end else if (f01a && (edge_cnt_q != LIM)) begin
      edge_cnt_d = edge_cnt_q + EW'(1);
    end
    if (run_entry) begin
      scafal_d = 1'b0;
    end else if (running && (edge_cnt_q == LIM)) begin
      scafal_d = 1'b1;
    end
  end

  assign scafal = scafal_q;

endmodule

// File: rtl/scaler_prescaler.sv
// Divides SIM_CLK to the first scaler phase FS01 with runt-free start/stop.
// Define SCALER_ALARM_EN to add the FS02 watchdog driving SCAFAL.
module scaler_prescaler
  import scaler_pkg::*;
#(
  parameter int unsigned DIV_HALF    = SCALER_DIV_HALF_DEF,
  parameter int unsigned ALARM_LIMIT = SCALER_ALARM_LIMIT_DEF
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic STRT,
  input  logic STOP,
  input  logic FS02,
  output logic FS01,
  output logic FS01_,
  output logic F01A,
  output logic F01B,
  output logic RUNNING,
  output logic SCAFAL
);

  localparam int unsigned   CW = cnt_width(DIV_HALF);
  localparam logic [CW-1:0] TC = CW'(DIV_HALF - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fs01_q, fs01_d;
  logic          fs01_n_q, fs01_n_d;
  logic          f01a_q, f01a_d;
  logic          f01b_q, f01b_d;
  logic          running_q, running_d;
  logic          stop_pend_q, stop_pend_d;
  logic          run_entry;
  logic          tc;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fs01_q      <= 1'b0;
      fs01_n_q    <= 1'b1;
      f01a_q      <= 1'b0;
      f01b_q      <= 1'b0;
      running_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fs01_q      <= fs01_d;
      fs01_n_q    <= fs01_n_d;
      f01a_q      <= f01a_d;
      f01b_q      <= f01b_d;
      running_q   <= running_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // A stop only takes effect on a falling terminal count, so the last high phase is full width.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fs01_d      = fs01_q;
    stop_pend_d = stop_pend_q;
    f01a_d      = 1'b0;
    f01b_d      = 1'b0;
    run_entry   = 1'b0;
    tc          = (cnt_q == TC);
    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        fs01_d      = 1'b0;
        stop_pend_d = 1'b0;
        if (STRT && !STOP) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          stop_pend_d = 1'b1;
        end
        if (tc) begin
          cnt_d  = '0;
          fs01_d = ~fs01_q;
          f01a_d = ~fs01_q;
          f01b_d = fs01_q;
          if (fs01_q && (stop_pend_q || STOP)) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    fs01_n_d  = ~fs01_d;
    running_d = (state_d == RUN);
  end

  assign FS01    = fs01_q;
  assign FS01_   = fs01_n_q;
  assign F01A    = f01a_q;
  assign F01B    = f01b_q;
  assign RUNNING = running_q;

`ifdef SCALER_ALARM_EN
  scaler_alarm_mon #(
    .ALARM_LIMIT(ALARM_LIMIT)
  ) u_alarm (
    .clk      (SIM_CLK),
    .rst      (SIM_RST),
    .fs02     (FS02),
    .f01a     (f01a_q),
    .running  (running_q),
    .run_entry(run_entry),
    .scafal   (SCAFAL)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{FS02, run_entry, 32'(ALARM_LIMIT)};
  assign SCAFAL    = 1'b0;
`endif

endmodule

// File: tb/tb_scaler_prescaler.sv
// Self-checking bench for scaler_prescaler at DIV_HALF=3, ALARM_LIMIT=4.
module tb_scaler_prescaler;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic STRT = 1'b0;
  logic STOP = 1'b0;
  logic FS02 = 1'b0;
  logic FS01, FS01_, F01A, F01B, RUNNING, SCAFAL;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;
  ev_t exp_q[$];

  scaler_prescaler #(.DIV_HALF(3), .ALARM_LIMIT(4)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .STRT(STRT), .STOP(STOP), .FS02(FS02),
    .FS01(FS01), .FS01_(FS01_), .F01A(F01A), .F01B(F01B), .RUNNING(RUNNING), .SCAFAL(SCAFAL)
  );

  always #5 SIM_CLK = ~SIM_CLK;
  always @(posedge SIM_CLK) cyc <= cyc + 1;

  task automatic test_reset();
    @(negedge SIM_CLK);
    n_cmp++;
    if ({FS01, FS01_, F01A, F01B, RUNNING, SCAFAL} !== 6'b010000) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=010000", {FS01, FS01_, F01A, F01B, RUNNING, SCAFAL});
    end
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
  endtask

  task automatic test_start_period();
    int e;
    ev_t ev;
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    e = cyc;
    n_cmp++;
    if (RUNNING !== 1'b1) begin
      n_bad++;
      $display("FAIL start_running got=%b want=1", RUNNING);
    end
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back('{e + 3 + 6 * p, 1'b1});
      exp_q.push_back('{e + 6 + 6 * p, 1'b0});
    end
    for (int i = 0; i < 26; i++) begin
      @(negedge SIM_CLK);
      n_cmp++;
      if (FS01_ !== ~FS01 || (F01A && F01B)) begin
        n_bad++;
        $display("FAIL period_compl cyc=%0d fs01=%b fs01_=%b a=%b b=%b", cyc, FS01, FS01_, F01A, F01B);
      end
      if (F01A || F01B) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL period_extra_strobe cyc=%0d a=%b", cyc, F01A);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.rise != F01A || FS01 !== F01A) begin
            n_bad++;
            $display("FAIL period_edge got cyc=%0d rise=%b fs01=%b want cyc=%0d rise=%b",
                     cyc, F01A, FS01, ev.cyc, ev.rise);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL period_missing got=%0d pending want=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stop_low();
    int f = -1;
    int hi = 0;
    ev_t ev;
    for (int i = 0; i < 12 && f < 0; i++) begin
      @(negedge SIM_CLK);
      if (F01B) f = cyc;
    end
    n_cmp++;
    if (f < 0) begin
      n_bad++;
      $display("FAIL stop_low_timeout got=no_F01B want=F01B");
      return;
    end
    STOP = 1'b1;
    exp_q.push_back('{f + 3, 1'b1});
    exp_q.push_back('{f + 6, 1'b0});
    @(negedge SIM_CLK);
    STOP = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (FS01) hi++;
      if (F01A || F01B) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stop_low_extra_strobe cyc=%0d", cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.rise != F01A) begin
            n_bad++;
            $display("FAIL stop_low_edge got cyc=%0d rise=%b want cyc=%0d rise=%b", cyc, F01A, ev.cyc, ev.rise);
          end
        end
      end
      if (cyc == f + 5 || cyc == f + 6) begin
        n_cmp++;
        if (RUNNING !== (cyc == f + 5)) begin
          n_bad++;
          $display("FAIL stop_low_running cyc=%0d got=%b want=%b", cyc, RUNNING, cyc == f + 5);
        end
      end
      if (cyc > f + 6) begin
        n_cmp++;
        if ({FS01, F01A, F01B, RUNNING} !== 4'b0000) begin
          n_bad++;
          $display("FAIL stop_low_idle cyc=%0d got=%b want=0000", cyc, {FS01, F01A, F01B, RUNNING});
        end
      end
      @(negedge SIM_CLK);
    end
    n_cmp++;
    if (hi != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stop_low_width got hi=%0d pending=%0d want hi=3 pending=0", hi, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stop_high();
    int a = -1;
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    for (int i = 0; i < 8 && a < 0; i++) begin
      @(negedge SIM_CLK);
      if (F01A) a = cyc;
    end
    n_cmp++;
    if (a < 0) begin
      n_bad++;
      $display("FAIL stop_high_timeout got=no_F01A want=F01A");
      return;
    end
    STOP = 1'b1;
    exp_q.push_back('{a + 3, 1'b0});
    @(negedge SIM_CLK);
    STOP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (F01A || F01B) begin
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || !F01B) begin
          n_bad++;
          $display("FAIL stop_high_edge got cyc=%0d a=%b b=%b want cyc=%0d fall", cyc, F01A, F01B, a + 3);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (cyc == a + 2 || cyc == a + 3) begin
        n_cmp++;
        if (RUNNING !== (cyc == a + 2)) begin
          n_bad++;
          $display("FAIL stop_high_running cyc=%0d got=%b want=%b", cyc, RUNNING, cyc == a + 2);
        end
      end
      @(negedge SIM_CLK);
    end
    n_cmp++;
    if (exp_q.size() != 0 || FS01 !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_high_end got pending=%0d fs01=%b want 0/0", exp_q.size(), FS01);
    end
    exp_q.delete();
  endtask

  task automatic test_both_high();
    STRT = 1'b1;
    STOP = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge SIM_CLK);
      n_cmp++;
      if ({FS01, F01A, F01B, RUNNING} !== 4'b0000) begin
        n_bad++;
        $display("FAIL both_high cyc=%0d got=%b want=0000", cyc, {FS01, F01A, F01B, RUNNING});
      end
    end
    STRT = 1'b0;
    STOP = 1'b0;
    @(negedge SIM_CLK);
  endtask

  task automatic test_reset_mid();
    int a = -1;
    int e;
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    for (int i = 0; i < 8 && a < 0; i++) begin
      @(negedge SIM_CLK);
      if (F01A) a = cyc;
    end
    @(negedge SIM_CLK);
    n_cmp++;
    if (a < 0 || FS01 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_setup got a=%0d fs01=%b want high phase", a, FS01);
    end
    #2 SIM_RST = 1'b1;
    #1;
    n_cmp++;
    if ({FS01, FS01_, F01A, F01B, RUNNING, SCAFAL} !== 6'b010000) begin
      n_bad++;
      $display("FAIL rst_mid_async got=%b want=010000", {FS01, FS01_, F01A, F01B, RUNNING, SCAFAL});
    end
    @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    e = cyc;
    exp_q.push_back('{e + 3, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(negedge SIM_CLK);
      if (F01A || F01B) begin
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || !F01A) begin
          n_bad++;
          $display("FAIL rst_mid_restart got cyc=%0d a=%b want cyc=%0d rise", cyc, F01A, e + 3);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_missing got=%0d pending want=0", exp_q.size());
    end
    exp_q.delete();
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
  endtask

  task automatic stop_and_wait(input string tag);
    bit idle = 0;
    STOP = 1'b1;
    @(negedge SIM_CLK);
    STOP = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge SIM_CLK);
      if (!RUNNING) idle = 1;
    end
    n_cmp++;
    if (!idle) begin
      n_bad++;
      $display("FAIL %s_stop_timeout got=RUNNING want=idle", tag);
    end
  endtask

`ifdef SCALER_ALARM_EN
  task automatic test_alarm();
    int k = 0;
    int a4 = -1;
    FS02 = 1'b0;
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    for (int i = 0; i < 40 && a4 < 0; i++) begin
      @(negedge SIM_CLK);
      if (F01A) begin
        k++;
        if (k >= 3) begin
          n_cmp++;
          if (SCAFAL !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_early rise=%0d got=%b want=0", k, SCAFAL);
          end
        end
        if (k == 4) a4 = cyc;
      end
    end
    repeat (2) @(negedge SIM_CLK);
    n_cmp++;
    if (a4 < 0 || SCAFAL !== 1'b1) begin
      n_bad++;
      $display("FAIL alarm_set got=%b want=1 a4=%0d", SCAFAL, a4);
    end
    stop_and_wait("alarm");
    repeat (3) @(negedge SIM_CLK);
    n_cmp++;
    if (SCAFAL !== 1'b1) begin
      n_bad++;
      $display("FAIL alarm_sticky got=%b want=1", SCAFAL);
    end
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    n_cmp++;
    if (SCAFAL !== 1'b0 || RUNNING !== 1'b1) begin
      n_bad++;
      $display("FAIL alarm_clear got scafal=%b running=%b want 0/1", SCAFAL, RUNNING);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge SIM_CLK);
      if (F01A) FS02 = ~FS02;
      n_cmp++;
      if (SCAFAL !== 1'b0) begin
        n_bad++;
        $display("FAIL alarm_healthy cyc=%0d got=%b want=0", cyc, SCAFAL);
      end
    end
    stop_and_wait("healthy");
  endtask
`else
  task automatic test_scafal_off();
    FS02 = 1'b0;
    STRT = 1'b1;
    @(negedge SIM_CLK);
    STRT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge SIM_CLK);
      n_cmp++;
      if (SCAFAL !== 1'b0) begin
        n_bad++;
        $display("FAIL scafal_off cyc=%0d got=%b want=0", cyc, SCAFAL);
      end
    end
    stop_and_wait("scafal_off");
  endtask
`endif

  initial begin
    test_reset();
    test_start_period();
    test_stop_low();
    test_stop_high();
    test_both_high();
    test_reset_mid();
`ifdef SCALER_ALARM_EN
    test_alarm();
`else
    test_scafal_off();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
